// File: rtl/spi_xfer_sequencer.sv
// MCU-to-SPI transfer sequencer: synchronises MCU strobes, queues TX bytes,
// drives one go/wait/capture handshake per byte and collects replies in an RX FIFO.
module spi_xfer_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mc_we,
  input  logic              mc_oe,
  input  logic [ADDR_W-1:0] mc_add,
  input  logic [DATA_W-1:0] mc_din,
  output logic [DATA_W-1:0] mc_dout,
  output logic              spi_go,
  output logic [7:0]        spi_din,
  input  logic              spi_state,
  input  logic [7:0]        spi_dout,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GO = 2'd1, S_WAIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        we_sync_q, we_sync_d, oe_sync_q, oe_sync_d;
  logic [1:0]        tmo_q, tmo_d;
  logic              spi_go_q, spi_go_d, irq_q, irq_d, irq_en_q, irq_en_d;
  logic              tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, drop_q, drop_d;
  logic [7:0]        spi_din_q, spi_din_d;
  logic [DATA_W-1:0] mc_dout_q, mc_dout_d;
  logic [LW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0]        tx_mem_q [FIFO_DEPTH], tx_mem_d [FIFO_DEPTH];
  logic [7:0]        rx_mem_q [FIFO_DEPTH], rx_mem_d [FIFO_DEPTH];

  logic          we_rise_s, oe_rise_s, wr_tx_s, wr_ctl_s, flush_s, clr_s, rd_rx_s;
  logic [LW-1:0] tx_level_s, rx_level_s;
  logic          tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic          start_s, tx_push_s, rx_push_s, rx_pop_s;
  logic [15:0]   status_s;
  logic          unused_ok;

  assign unused_ok = ^mc_din[DATA_W-1:8];

  always_comb begin
    we_sync_d  = {we_sync_q[1:0], mc_we};
    oe_sync_d  = {oe_sync_q[1:0], mc_oe};
    we_rise_s  = we_sync_q[1] & ~we_sync_q[2];
    oe_rise_s  = oe_sync_q[1] & ~oe_sync_q[2];
    wr_tx_s    = we_rise_s && (mc_add == ADDR_W'(0));
    wr_ctl_s   = we_rise_s && (mc_add == ADDR_W'(3));
    rd_rx_s    = oe_rise_s && (mc_add == ADDR_W'(1));
    flush_s    = wr_ctl_s & mc_din[0];
    clr_s      = wr_ctl_s & mc_din[2];

    tx_level_s = tx_wp_q - tx_rp_q;
    rx_level_s = rx_wp_q - rx_rp_q;
    tx_empty_s = (tx_level_s == LW'(0));
    rx_empty_s = (rx_level_s == LW'(0));
    tx_full_s  = (tx_level_s == LW'(FIFO_DEPTH));
    rx_full_s  = (rx_level_s == LW'(FIFO_DEPTH));

    // RX must have room before a start, so a capture never finds it full
    start_s    = (state_q == S_IDLE) && !tx_empty_s && !rx_full_s;
    tx_push_s  = wr_tx_s && !flush_s && (!tx_full_s || start_s);
    rx_push_s  = (state_q == S_WAIT) && !spi_state && !drop_q && !flush_s;
    rx_pop_s   = rd_rx_s && !rx_empty_s;

    state_d   = state_q;
    tmo_d     = tmo_q;
    spi_go_d  = 1'b0;
    spi_din_d = spi_din_q;
    drop_d    = drop_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d   = S_GO;
          spi_go_d  = 1'b1;
          spi_din_d = tx_mem_q[tx_rp_q[AW-1:0]];
          tmo_d     = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GO: begin
        if (spi_state) begin
          state_d = S_WAIT;
        end else if (tmo_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (!spi_state) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush while a byte is on the wire marks its reply for discard
    if (start_s) begin
      drop_d = flush_s;
    end else if (flush_s && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end

    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push_s) tx_mem_d[tx_wp_q[AW-1:0]] = mc_din[7:0];
    else tx_mem_d = tx_mem_q;
    if (rx_push_s) rx_mem_d[rx_wp_q[AW-1:0]] = spi_dout;
    else rx_mem_d = rx_mem_q;

    if (flush_s) begin
      tx_wp_d = LW'(0);
      tx_rp_d = LW'(0);
      rx_wp_d = LW'(0);
      rx_rp_d = LW'(0);
    end else begin
      tx_wp_d = tx_wp_q + LW'(tx_push_s);
      tx_rp_d = tx_rp_q + LW'(start_s);
      rx_wp_d = rx_wp_q + LW'(rx_push_s);
      rx_rp_d = rx_rp_q + LW'(rx_pop_s);
    end

    tx_ovf_d = clr_s ? 1'b0 : tx_ovf_q;
    rx_unf_d = clr_s ? 1'b0 : rx_unf_q;
    if (wr_tx_s && tx_full_s && !start_s) tx_ovf_d = 1'b1;
    else tx_ovf_d = tx_ovf_d;
    if (rd_rx_s && rx_empty_s) rx_unf_d = 1'b1;
    else rx_unf_d = rx_unf_d;
    irq_en_d = wr_ctl_s ? mc_din[1] : irq_en_q;

    status_s = {tx_ovf_q, rx_unf_q, (state_q != S_IDLE), 5'(rx_level_s), 3'b000, 5'(tx_level_s)};
    case (mc_add)
      ADDR_W'(1): mc_dout_d = rx_empty_s ? DATA_W'(0) : DATA_W'(rx_mem_q[rx_rp_q[AW-1:0]]);
      ADDR_W'(2): mc_dout_d = DATA_W'(status_s);
      default:    mc_dout_d = DATA_W'(0);
    endcase

    irq_d = irq_en_q && (state_q == S_IDLE) && tx_empty_s && !rx_empty_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      we_sync_q <= 3'b000;
      oe_sync_q <= 3'b111;  // mc_oe idles high; avoids a false end-of-read after reset
      tmo_q     <= 2'd0;
      spi_go_q  <= 1'b0;
      spi_din_q <= 8'h00;
      mc_dout_q <= DATA_W'(0);
      irq_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      drop_q    <= 1'b0;
      tx_wp_q   <= LW'(0);
      tx_rp_q   <= LW'(0);
      rx_wp_q   <= LW'(0);
      rx_rp_q   <= LW'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      we_sync_q <= we_sync_d;
      oe_sync_q <= oe_sync_d;
      tmo_q     <= tmo_d;
      spi_go_q  <= spi_go_d;
      spi_din_q <= spi_din_d;
      mc_dout_q <= mc_dout_d;
      irq_q     <= irq_d;
      irq_en_q  <= irq_en_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      drop_q    <= drop_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
    end
  end

  assign mc_dout = mc_dout_q;
  assign spi_go  = spi_go_q;
  assign spi_din = spi_din_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a vector table for register-level flows
// plus hand-written sequences for overflow, flush, timeout, irq and mid-transfer reset.
module tb_spi_xfer_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mc_we = 1'b0;
  logic        mc_oe = 1'b1;
  logic [5:0]  mc_add = 6'd0;
  logic [15:0] mc_din = 16'd0;
  logic [15:0] mc_dout;
  logic        spi_go;
  logic [7:0]  spi_din;
  logic        spi_state;
  logic [7:0]  spi_dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  spi_xfer_sequencer dut (
    .clock(clock), .reset(reset), .mc_we(mc_we), .mc_oe(mc_oe), .mc_add(mc_add),
    .mc_din(mc_din), .mc_dout(mc_dout), .spi_go(spi_go), .spi_din(spi_din),
    .spi_state(spi_state), .spi_dout(spi_dout), .irq(irq)
  );

  always #5 clock = ~clock;

  // SPI master stub: 0 = echo ~data after 4 busy cycles, 1 = stall busy, 2 = never respond
  int        stub_mode = 0;
  logic [1:0] stub_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_state <= 1'b0;
      spi_dout  <= 8'h00;
      stub_cnt  <= 2'd0;
    end else if (spi_go && stub_mode != 2) begin
      spi_state <= 1'b1;
      spi_dout  <= ~spi_din;
      stub_cnt  <= 2'd3;
    end else if (spi_state && stub_mode == 0) begin
      if (stub_cnt == 2'd0) spi_state <= 1'b0;
      else stub_cnt <= stub_cnt - 2'd1;
    end
  end

  int         go_count = 0;
  int         cyc = 0;
  int         last_go = -100;
  int         min_gap = 1000;
  int         go_in_reset = 0;
  logic [7:0] din_log [$];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (spi_go) begin
      go_count <= go_count + 1;
      din_log.push_back(spi_din);
      if (cyc - last_go < min_gap) min_gap <= cyc - last_go;
      last_go <= cyc;
    end
  end
  always @(negedge clock) if (reset && spi_go) go_in_reset <= go_in_reset + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clock);
    mc_add = a; mc_din = d; mc_we = 1'b1;
    repeat (4) @(negedge clock);
    mc_we = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    @(negedge clock);
    mc_add = a; mc_oe = 1'b0;
    repeat (4) @(negedge clock);
    d = mc_dout;
    mc_oe = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    go_count = 0;
    din_log.delete();
    @(negedge clock);
  endtask

  localparam logic [1:0] OP_W = 2'd0, OP_R = 2'd1, OP_IDLE = 2'd2;
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  add;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [15];
  logic [15:0] rdata;

  initial begin
    // reset/idle, two-byte echo, unmapped addresses, RX underflow and sticky clear
    vecs[0]  = '{OP_R,    6'h02, 16'h0000, 16'h0000};
    vecs[1]  = '{OP_R,    6'h3F, 16'h0000, 16'h0000};
    vecs[2]  = '{OP_W,    6'h05, 16'h00FF, 16'h0000};
    vecs[3]  = '{OP_R,    6'h02, 16'h0000, 16'h0000};
    vecs[4]  = '{OP_W,    6'h00, 16'h00A5, 16'h0000};
    vecs[5]  = '{OP_W,    6'h00, 16'h003C, 16'h0000};
    vecs[6]  = '{OP_IDLE, 6'h00, 16'h0000, 16'h0000};
    vecs[7]  = '{OP_R,    6'h02, 16'h0000, 16'h0200};
    vecs[8]  = '{OP_R,    6'h01, 16'h0000, 16'h005A};
    vecs[9]  = '{OP_R,    6'h01, 16'h0000, 16'h00C3};
    vecs[10] = '{OP_R,    6'h02, 16'h0000, 16'h0000};
    vecs[11] = '{OP_R,    6'h01, 16'h0000, 16'h0000};
    vecs[12] = '{OP_R,    6'h02, 16'h0000, 16'h4000};
    vecs[13] = '{OP_W,    6'h03, 16'h0004, 16'h0000};
    vecs[14] = '{OP_R,    6'h02, 16'h0000, 16'h0000};

    repeat (2) @(negedge clock);
    chk("reset_outputs", {15'd0, spi_go, irq, spi_din, mc_dout}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("idle_no_go", go_count, 32'd0);
    chk("idle_outputs", {15'd0, spi_go, irq, spi_din, mc_dout}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      case (vecs[i].op)
        OP_W:    wr(vecs[i].add, vecs[i].din);
        OP_R: begin
          rd(vecs[i].add, rdata);
          chk($sformatf("vec%0d_rd%0h", i, vecs[i].add), {16'd0, rdata}, {16'd0, vecs[i].exp});
        end
        default: repeat (40) @(negedge clock);
      endcase
    end
    chk("echo_go_count", go_count, 32'd2);
    chk("echo_din0", {24'd0, din_log[0]}, 32'h0000_00A5);
    chk("echo_din1", {24'd0, din_log[1]}, 32'h0000_003C);
    chk("go_spacing_ge3", {31'd0, (min_gap >= 3)}, 32'd1);

    // TX overflow: the first byte is held on the wire, so 16 more fill the FIFO
    do_reset();
    stub_mode = 1;
    for (int i = 0; i < 17; i++) wr(6'h00, 16'(i));
    rd(6'h02, rdata);
    chk("full_status", {16'd0, rdata}, 32'h0000_2010);
    wr(6'h00, 16'h00EE);
    rd(6'h02, rdata);
    chk("overflow_status", {16'd0, rdata}, 32'h0000_A010);
    wr(6'h03, 16'h0004);
    rd(6'h02, rdata);
    chk("overflow_cleared", {16'd0, rdata}, 32'h0000_2010);

    // Flush with one byte in flight and three queued
    do_reset();
    stub_mode = 1;
    for (int i = 0; i < 4; i++) wr(6'h00, 16'h0010 + 16'(i));
    rd(6'h02, rdata);
    chk("preflush_status", {16'd0, rdata}, 32'h0000_2003);
    wr(6'h03, 16'h0001);
    rd(6'h02, rdata);
    chk("postflush_status", {16'd0, rdata}, 32'h0000_2000);
    stub_mode = 0;
    repeat (20) @(negedge clock);
    rd(6'h02, rdata);
    chk("flush_rx_dropped", {16'd0, rdata}, 32'h0000_0000);
    chk("flush_go_count", go_count, 32'd1);
    chk("flush_din_held", {24'd0, spi_din}, 32'h0000_0010);

    // SPI master never answers: sequencer gives up and returns idle
    do_reset();
    stub_mode = 2;
    wr(6'h00, 16'h0077);
    repeat (10) @(negedge clock);
    rd(6'h02, rdata);
    chk("timeout_status", {16'd0, rdata}, 32'h0000_0000);
    chk("timeout_go_count", go_count, 32'd1);

    // irq after capture, cleared by draining RX; then reset while in WAIT
    do_reset();
    stub_mode = 0;
    wr(6'h03, 16'h0002);
    chk("irq_low_empty", {31'd0, irq}, 32'd0);
    wr(6'h00, 16'h0011);
    repeat (30) @(negedge clock);
    chk("irq_high", {31'd0, irq}, 32'd1);
    rd(6'h01, rdata);
    chk("irq_rx_data", {16'd0, rdata}, 32'h0000_00EE);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    stub_mode = 1;
    wr(6'h00, 16'h0022);
    mc_add = 6'h02;
    repeat (4) @(negedge clock);
    chk("wait_status", {16'd0, mc_dout}, 32'h0000_2000);
    chk("wait_din", {24'd0, spi_din}, 32'h0000_0022);
    #2 reset = 1'b1;
    #1;
    chk("midxfer_reset", {15'd0, spi_go, irq, spi_din, mc_dout}, 32'd0);
    repeat (3) @(negedge clock);
    chk("no_go_in_reset", go_in_reset, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
